// File: rtl/biriscv_icache_port_arb_if.sv
// Instruction-cache port bundle: two requester channels plus the cache side.
// The arbiter takes the slave view. The environment (requesters and cache) takes the master view.
interface biriscv_icache_port_arb_if;
    // Requester 0 (fetch)
    logic        req0_rd_i;
    logic [31:0] req0_pc_i;
    logic [1:0]  req0_priv_i;
    logic        req0_kill_i;
    logic        req0_flush_i;
    logic        req0_accept_o;
    logic        req0_valid_o;
    // Requester 1 (prefetcher / debug reader)
    logic        req1_rd_i;
    logic [31:0] req1_pc_i;
    logic [1:0]  req1_priv_i;
    logic        req1_kill_i;
    logic        req1_flush_i;
    logic        req1_accept_o;
    logic        req1_valid_o;
    // Shared response
    logic [63:0] resp_inst_o;
    logic        resp_error_o;
    logic        resp_page_fault_o;
    // Cache side
    logic        icache_rd_o;
    logic [31:0] icache_pc_o;
    logic [1:0]  icache_priv_o;
    logic        icache_flush_o;
    logic        icache_accept_i;
    logic        icache_valid_i;
    logic [63:0] icache_inst_i;
    logic        icache_error_i;
    logic        icache_page_fault_i;

    modport slave (
        input  req0_rd_i, req0_pc_i, req0_priv_i, req0_kill_i, req0_flush_i,
        output req0_accept_o, req0_valid_o,
        input  req1_rd_i, req1_pc_i, req1_priv_i, req1_kill_i, req1_flush_i,
        output req1_accept_o, req1_valid_o,
        output resp_inst_o, resp_error_o, resp_page_fault_o,
        output icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o,
        input  icache_accept_i, icache_valid_i, icache_inst_i,
        input  icache_error_i, icache_page_fault_i
    );

    modport master (
        output req0_rd_i, req0_pc_i, req0_priv_i, req0_kill_i, req0_flush_i,
        input  req0_accept_o, req0_valid_o,
        output req1_rd_i, req1_pc_i, req1_priv_i, req1_kill_i, req1_flush_i,
        input  req1_accept_o, req1_valid_o,
        input  resp_inst_o, resp_error_o, resp_page_fault_o,
        input  icache_rd_o, icache_pc_o, icache_priv_o, icache_flush_o,
        output icache_accept_i, icache_valid_i, icache_inst_i,
        output icache_error_i, icache_page_fault_i
    );
endinterface

// File: rtl/biriscv_icache_port_arb.sv
// Two-requester arbiter for the single icache read port.
// It allows one outstanding read and routes each response to the requester that issued it.
// A requester can cancel its own in-flight read.
// Flushes are held off until no read is outstanding.
module biriscv_icache_port_arb #(
    parameter bit SUPPORT_MMU = 1'b1,
    parameter bit FIXED_PRIO  = 1'b0
) (
    input logic                       clk_i,
    input logic                       rst_i,
    biriscv_icache_port_arb_if.slave  bus
);

    logic r_busy;        // a read is outstanding
    logic r_owner;       // requester that owns the outstanding read
    logic r_drop;        // outstanding response is to be discarded
    logic r_flush_pend;  // flush waiting for the port to go free
    logic r_rr;          // round-robin pointer: requester with priority next

    logic        w_free;
    logic        w_flush_req;
    logic        w_grant;
    logic        w_rd_acc;
    logic        w_owner_kill;
    logic [31:0] w_pc;
    logic [1:0]  w_priv;

    // Grant, flush sequencing and response routing (all outputs combinational)
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        w_free       = !r_busy | bus.icache_valid_i;
        w_flush_req  = r_flush_pend | bus.req0_flush_i | bus.req1_flush_i;

        w_grant = 1'b0;
        if (bus.req0_rd_i && bus.req1_rd_i)
            w_grant = FIXED_PRIO ? 1'b0 : r_rr;
        else if (bus.req1_rd_i)
            w_grant = 1'b1;

        w_pc   = w_grant ? bus.req1_pc_i   : bus.req0_pc_i;
        w_priv = w_grant ? bus.req1_priv_i : bus.req0_priv_i;

        bus.icache_flush_o = w_free & w_flush_req;
        bus.icache_rd_o    = w_free & !w_flush_req & (bus.req0_rd_i | bus.req1_rd_i);
        bus.icache_pc_o    = w_pc & 32'hFFFF_FFF8;
        bus.icache_priv_o  = SUPPORT_MMU ? w_priv : 2'b11;

        w_rd_acc          = bus.icache_rd_o & bus.icache_accept_i;
        bus.req0_accept_o = w_rd_acc & !w_grant;
        bus.req1_accept_o = w_rd_acc &  w_grant;

        w_owner_kill     = r_owner ? bus.req1_kill_i : bus.req0_kill_i;
        bus.req0_valid_o = bus.icache_valid_i & r_busy & !r_owner & !r_drop & !w_owner_kill;
        bus.req1_valid_o = bus.icache_valid_i & r_busy &  r_owner & !r_drop & !w_owner_kill;

        bus.resp_inst_o       = bus.icache_inst_i;
        bus.resp_error_o      = bus.icache_error_i;
        bus.resp_page_fault_o = bus.icache_page_fault_i;
    end

    // Outstanding-read tracking, kill capture, flush pending and round-robin pointer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy       <= 1'b0;
            r_owner      <= 1'b0;
            r_drop       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_rr         <= 1'b0;
        end else begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            if (w_flush_req)
                r_flush_pend <= !(w_free & bus.icache_accept_i);

            if (w_rd_acc) begin
                r_busy  <= 1'b1;
                r_owner <= w_grant;
                r_drop  <= 1'b0;
                r_rr    <= ~w_grant;
            end else if (bus.icache_valid_i) begin
                r_busy <= 1'b0;
                r_drop <= 1'b0;
            end else if (r_busy && w_owner_kill) begin
                r_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_biriscv_icache_port_arb.sv
// Directed bench for biriscv_icache_port_arb.
// When a read is issued, the stimulus pushes the response it expects to be forwarded.
// A negedge monitor pops that entry whenever a valid_o appears and compares it.
module tb_biriscv_icache_port_arb;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    biriscv_icache_port_arb_if bus ();

    biriscv_icache_port_arb #(
        .SUPPORT_MMU (1'b1),
        .FIXED_PRIO  (1'b0)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        owner;
        logic [63:0] inst;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total_cnt = 0;
    int   bad_cnt   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.req0_rd_i = 0; bus.req0_pc_i = 0; bus.req0_priv_i = 0;
        bus.req0_kill_i = 0; bus.req0_flush_i = 0;
        bus.req1_rd_i = 0; bus.req1_pc_i = 0; bus.req1_priv_i = 0;
        bus.req1_kill_i = 0; bus.req1_flush_i = 0;
        bus.icache_accept_i = 0; bus.icache_valid_i = 0; bus.icache_inst_i = 0;
        bus.icache_error_i = 0; bus.icache_page_fault_i = 0;
    endtask

    task automatic check_grant(input string name, input logic rd, input logic [31:0] pc,
                               input logic a0, input logic a1);
        check({name, "_rd"},  bus.icache_rd_o, rd);
        if (rd) check({name, "_pc"}, bus.icache_pc_o, pc);
        check({name, "_acc0"}, bus.req0_accept_o, a0);
        check({name, "_acc1"}, bus.req1_accept_o, a1);
    endtask

    // Scoreboard monitor: every forwarded response must match the oldest expected entry
    always @(negedge clk_i) begin
        if (!rst_i && (bus.req0_valid_o || bus.req1_valid_o)) begin
            check("mon_single_valid", bus.req0_valid_o & bus.req1_valid_o, 0);
            if (sb.size() == 0) begin
                check("mon_unexpected_valid", {bus.req1_valid_o, bus.req0_valid_o}, 0);
            end else begin
                mon_e = sb.pop_front();
                check("mon_owner", bus.req1_valid_o, mon_e.owner);
                check("mon_inst", bus.resp_inst_o, mon_e.inst);
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [63:0] rr_data [4];
    logic        rr_grant [4];

    initial begin
        idle_inputs();
        rr_data[0] = 64'hA0A0_0000_0000_0001; rr_data[1] = 64'hB1B1_0000_0000_0002;
        rr_data[2] = 64'hA2A2_0000_0000_0003; rr_data[3] = 64'hB3B3_0000_0000_0004;
        rr_grant[0] = 1; rr_grant[1] = 0; rr_grant[2] = 1; rr_grant[3] = 0;

        repeat (3) tick();
        rst_i = 0;
        settle();
        // Reset state: idle inputs give all-zero outputs
        check("rst_rd",    bus.icache_rd_o, 0);
        check("rst_flush", bus.icache_flush_o, 0);
        check("rst_pc",    bus.icache_pc_o, 0);
        check("rst_priv",  bus.icache_priv_o, 0);
        check("rst_acc",   {bus.req1_accept_o, bus.req0_accept_o}, 0);
        check("rst_valid", {bus.req1_valid_o, bus.req0_valid_o}, 0);
        tick();

        // T1: single fetch read, response three cycles later
        bus.icache_accept_i = 1;
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h8000_0004; bus.req0_priv_i = 2'b11;
        settle();
        check_grant("t1", 1, 32'h8000_0000, 1, 0);
        check("t1_priv", bus.icache_priv_o, 2'b11);
        sb.push_back('{1'b0, 64'h1122_3344_5566_7788});
        tick();
        bus.req0_rd_i = 0;
        settle();
        check("t1_busy_no_rd", bus.icache_rd_o, 0);
        tick(); tick();
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h1122_3344_5566_7788;
        settle();
        check("t1_valid0", bus.req0_valid_o, 1);
        check("t1_valid1", bus.req1_valid_o, 0);
        tick();
        bus.icache_valid_i = 0;

        // T2: both requesting, back-to-back; rr starts at 1 after T1's grant to 0
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_1000; bus.req0_priv_i = 2'b11;
        bus.req1_rd_i = 1; bus.req1_pc_i = 32'h0000_200C; bus.req1_priv_i = 2'b01;
        for (int i = 0; i < 5; i++) begin
            bus.icache_valid_i = (i > 0);
            bus.icache_inst_i  = (i > 0) ? rr_data[i-1] : 64'h0;
            if (i == 4) begin
                bus.req0_rd_i = 0; bus.req1_rd_i = 0;
            end
            settle();
            if (i < 4) begin
                check_grant($sformatf("t2_%0d", i), 1,
                            rr_grant[i] ? 32'h0000_2008 : 32'h0000_1000,
                            !rr_grant[i], rr_grant[i]);
                check($sformatf("t2_priv_%0d", i), bus.icache_priv_o,
                      rr_grant[i] ? 2'b01 : 2'b11);
                sb.push_back('{rr_grant[i], rr_data[i]});
            end else begin
                check_grant("t2_end", 0, 0, 0, 0);
            end
            tick();
        end
        idle_inputs(); bus.icache_accept_i = 1;

        // T3: req1 read killed; non-owner kill has no effect
        bus.req1_rd_i = 1; bus.req1_pc_i = 32'h0000_3000;
        settle();
        check_grant("t3_g1", 1, 32'h0000_3000, 0, 1);
        tick();
        bus.req1_rd_i = 0; bus.req1_kill_i = 1;
        tick();
        bus.req1_kill_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_4000;
        settle();
        check("t3_killed_valid1", bus.req1_valid_o, 0);
        check_grant("t3_g0", 1, 32'h0000_4000, 1, 0);
        sb.push_back('{1'b0, 64'h0404_0404_0404_0404});
        tick();
        bus.icache_valid_i = 0; bus.req0_rd_i = 0; bus.req1_kill_i = 1;
        tick();
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h0404_0404_0404_0404;
        settle();
        check("t3_nonowner_kill_valid0", bus.req0_valid_o, 1);
        tick();
        idle_inputs(); bus.icache_accept_i = 1;

        // T4: flush during an outstanding read
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_5000;
        settle();
        check_grant("t4_g0", 1, 32'h0000_5000, 1, 0);
        sb.push_back('{1'b0, 64'h5555_5555_5555_5555});
        tick();
        bus.req0_rd_i = 0; bus.req0_flush_i = 1;
        bus.req1_rd_i = 1; bus.req1_pc_i = 32'h0000_6000;
        settle();
        check("t4_flush_held", bus.icache_flush_o, 0);
        check("t4_rd_blocked_busy", bus.icache_rd_o, 0);
        tick();
        bus.req0_flush_i = 0;
        settle();
        check("t4_flush_pending", bus.icache_flush_o, 0);
        tick();
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h5555_5555_5555_5555;
        bus.icache_error_i = 1;
        settle();
        check("t4_flush_issue", bus.icache_flush_o, 1);
        check_grant("t4_flush_cycle", 0, 0, 0, 0);
        check("t4_resp_error", bus.resp_error_o, 1);
        tick();
        bus.icache_valid_i = 0; bus.icache_error_i = 0;
        settle();
        check("t4_flush_once", bus.icache_flush_o, 0);
        check_grant("t4_g1", 1, 32'h0000_6000, 0, 1);
        sb.push_back('{1'b1, 64'h6666_6666_6666_6666});
        tick();
        bus.req1_rd_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h6666_6666_6666_6666;
        tick();
        idle_inputs();

        // T5: cache stalls accept for four cycles
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_7004;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_grant($sformatf("t5_stall_%0d", i), 1, 32'h0000_7000, 0, 0);
            tick();
        end
        bus.icache_accept_i = 1;
        settle();
        check_grant("t5_accept", 1, 32'h0000_7000, 1, 0);
        sb.push_back('{1'b0, 64'h7777_7777_7777_7777});
        tick();
        bus.req0_rd_i = 0;
        settle();
        check("t5_single_grant", bus.icache_rd_o, 0);
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h7777_7777_7777_7777;
        tick();
        bus.icache_valid_i = 0;

        // T6: reset mid-read, late response dropped, rr returns to requester 0
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_8000;
        settle();
        check_grant("t6_g0", 1, 32'h0000_8000, 1, 0);
        tick();
        bus.req0_rd_i = 0;
        rst_i = 1;
        tick();
        rst_i = 0;
        tick();
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'hBAD0_BAD0_BAD0_BAD0;
        settle();
        check("t6_late_valid", {bus.req1_valid_o, bus.req0_valid_o}, 0);
        tick();
        bus.icache_valid_i = 0;
        bus.req0_rd_i = 1; bus.req0_pc_i = 32'h0000_9000;
        bus.req1_rd_i = 1; bus.req1_pc_i = 32'h0000_A000;
        settle();
        check_grant("t6_rr_reset", 1, 32'h0000_9000, 1, 0);
        sb.push_back('{1'b0, 64'h9999_9999_9999_9999});
        tick();
        bus.req0_rd_i = 0; bus.req1_rd_i = 0;
        bus.icache_valid_i = 1; bus.icache_inst_i = 64'h9999_9999_9999_9999;
        tick();
        idle_inputs();
        tick();

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
